// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// Input stage of the 2x2 matrix multiplier. Collects operand bytes from a
// valid/ready byte stream into matrices A and B (row-major, element 0 in the
// low bits of each flattened bus), then holds both matrices behind a
// valid/ready handshake toward the multiply core.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   Undefined: frame is 8 bytes and err is held at 0.
//   Defined  : frame is 9 bytes; byte 8 must equal the XOR of bytes 0..7.
//              A mismatch sets the sticky err flag and restarts the frame.
module matrix_operand_loader #(
    parameter int ELEM_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                clear,
    input  logic [ELEM_W-1:0]   byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [4*ELEM_W-1:0] a_flat,
    output logic [4*ELEM_W-1:0] b_flat,
    output logic                operands_valid,
    input  logic                operands_ready,
    output logic [3:0]          load_count,
    output logic                err
);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               load_count_q, load_count_d;
    logic [3:0][ELEM_W-1:0]   a_q, a_d;
    logic [3:0][ELEM_W-1:0]   b_q, b_d;
    logic                     operands_valid_q, operands_valid_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [ELEM_W-1:0]        chk_q, chk_d;
`endif

    logic                     accept_s;
    logic                     handshake_s;
    logic                     abort_s;

    // Qualify the stream and output handshakes; clear overrides both.
    always_comb begin
        abort_s     = ena & clear;
        accept_s    = ena & ~clear & byte_valid & byte_ready_q;
        handshake_s = ena & ~clear & operands_valid_q & operands_ready;
    end

    // Next-state computation for the frame FSM, matrices and status flags.
    always_comb begin
        state_d          = state_q;
        load_count_d     = load_count_q;
        a_d              = a_q;
        b_d              = b_q;
        operands_valid_d = operands_valid_q;
        byte_ready_d     = byte_ready_q;
        err_d            = err_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d            = chk_q;
`endif
        if (abort_s) begin
            // Abort: restart the frame, matrix contents are left untouched.
            state_d          = ST_LOAD;
            load_count_d     = 4'd0;
            operands_valid_d = 1'b0;
            byte_ready_d     = 1'b1;
            err_d            = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_d            = {ELEM_W{1'b0}};
`endif
        end else if (accept_s) begin
            load_count_d = load_count_q + 4'd1;
            case (load_count_q)
                4'd0:    a_d[0] = byte_in;
                4'd1:    a_d[1] = byte_in;
                4'd2:    a_d[2] = byte_in;
                4'd3:    a_d[3] = byte_in;
                4'd4:    b_d[0] = byte_in;
                4'd5:    b_d[1] = byte_in;
                4'd6:    b_d[2] = byte_in;
                4'd7:    b_d[3] = byte_in;
                default: begin
                    // Checksum byte: compared, never stored.
                end
            endcase
`ifdef LOADER_CHECKSUM_EN
            chk_d = chk_q ^ byte_in;
`endif
            if (load_count_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                // chk_q holds the XOR of bytes 0..7 at this point.
                if (byte_in == chk_q) begin
                    state_d          = ST_FULL;
                    operands_valid_d = 1'b1;
                    byte_ready_d     = 1'b0;
                end else begin
                    err_d        = 1'b1;
                    load_count_d = 4'd0;
                    chk_d        = {ELEM_W{1'b0}};
                end
`else
                state_d          = ST_FULL;
                operands_valid_d = 1'b1;
                byte_ready_d     = 1'b0;
`endif
            end else begin
                // Mid-frame byte: keep loading.
            end
        end else if (handshake_s) begin
            state_d          = ST_LOAD;
            load_count_d     = 4'd0;
            operands_valid_d = 1'b0;
            byte_ready_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk_d            = {ELEM_W{1'b0}};
`endif
        end else begin
            // Idle, stalled, or disabled: hold everything.
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_LOAD;
            load_count_q     <= 4'd0;
            a_q              <= '0;
            b_q              <= '0;
            operands_valid_q <= 1'b0;
            byte_ready_q     <= 1'b1;
            err_q            <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q            <= {ELEM_W{1'b0}};
`endif
        end else begin
            state_q          <= state_d;
            load_count_q     <= load_count_d;
            a_q              <= a_d;
            b_q              <= b_d;
            operands_valid_q <= operands_valid_d;
            byte_ready_q     <= byte_ready_d;
            err_q            <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q            <= chk_d;
`endif
        end
    end

    assign byte_ready     = byte_ready_q;
    assign operands_valid = operands_valid_q;
    assign load_count     = load_count_q;
    assign a_flat         = a_q;
    assign b_flat         = b_q;
    assign err            = err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Testbench for matrix_operand_loader: a directed vector table, hand-written
// corner sequences, and randomized traffic checked against a frame-level model.
module tb_matrix_operand_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic        operands_valid;
    logic        operands_ready = 1'b0;
    logic [3:0]  load_count;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    matrix_operand_loader #(.ELEM_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .clear          (clear),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .a_flat         (a_flat),
        .b_flat         (b_flat),
        .operands_valid (operands_valid),
        .operands_ready (operands_ready),
        .load_count     (load_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    bit          m_full = 1'b0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    logic [7:0]  m_frame [9];
    logic [31:0] m_a = 32'h0;
    logic [31:0] m_b = 32'h0;

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 8; i++) x ^= m_frame[i];
        return x;
    endfunction

    task automatic model_clk(input logic r, input logic e, input logic c,
                             input logic bv, input logic [7:0] bi, input logic ordy);
        if (!r) begin
            m_full = 1'b0; m_err = 1'b0; m_cnt = 0; m_a = 32'h0; m_b = 32'h0;
        end else if (e) begin
            if (c) begin
                m_full = 1'b0; m_err = 1'b0; m_cnt = 0;
            end else if (!m_full) begin
                if (bv) begin
                    m_frame[m_cnt] = bi;
                    if (m_cnt < 4) m_a[8*m_cnt +: 8] = bi;
                    else if (m_cnt < 8) m_b[8*(m_cnt-4) +: 8] = bi;
                    m_cnt++;
                    if (m_cnt == FRAME) begin
                        if (FRAME == 9 && bi != frame_xor()) begin
                            m_err = 1'b1; m_cnt = 0;
                        end else begin
                            m_full = 1'b1;
                        end
                    end
                end
            end else if (ordy) begin
                m_full = 1'b0; m_cnt = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs #1 after the edge.
    task automatic apply(input logic r, input logic e, input logic c,
                         input logic bv, input logic [7:0] bi, input logic ordy);
        rst_n = r; ena = e; clear = c; byte_valid = bv; byte_in = bi; operands_ready = ordy;
        @(posedge clk);
        model_clk(r, e, c, bv, bi, ordy);
        #1;
        check("model_valid", {31'd0, operands_valid}, {31'd0, m_full});
        check("model_byte_ready", {31'd0, byte_ready}, {31'd0, ~m_full});
        check("model_load_count", {28'd0, load_count}, 32'(m_cnt));
        check("model_a_flat", a_flat, m_a);
        check("model_b_flat", b_flat, m_b);
        check("model_err", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic send(input logic [7:0] b);
        apply(1'b1, 1'b1, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] base);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send(base + 8'(i));
            x ^= base + 8'(i);
        end
        if (FRAME == 9) send(x);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, e, c, bv, ordy;
        logic [7:0]  bi;
        logic        ev, ebr, eerr;
        logic [3:0]  ecnt;
        logic [31:0] ea, eb;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, logic c, logic bv, logic [7:0] bi,
                                logic ordy, logic ev, logic ebr, logic [3:0] ecnt,
                                logic [31:0] ea, logic [31:0] eb, logic eerr);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.bv = bv; v.bi = bi; v.ordy = ordy;
        v.ev = ev; v.ebr = ebr; v.ecnt = ecnt; v.ea = ea; v.eb = eb; v.eerr = eerr;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ev;
        logic        r, e, c, bv, ordy;
        logic [7:0]  bi;

        // Reset held 2 cycles, then frame 0x01..0x08 with operands_ready low,
        // 5 stall cycles offering 0xFF, then the output handshake.
        ea = 32'h0; eb = 32'h0;
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            if (i < 4) ea[8*i +: 8] = 8'(i + 1);
            else       eb[8*(i-4) +: 8] = 8'(i + 1);
            ev = (FRAME == 8) && (i == 7);
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'(i + 1), 1'b0, ev, ~ev, 4'(i + 1), ea, eb, 1'b0));
        end
        if (FRAME == 9)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 4'd9, ea, eb, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 4'(FRAME),
                             32'h04030201, 32'h08070605, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0,
                         32'h04030201, 32'h08070605, 1'b0));

        for (int t = 0; t < tbl.size(); t++) begin
            apply(tbl[t].r, tbl[t].e, tbl[t].c, tbl[t].bv, tbl[t].bi, tbl[t].ordy);
            check("tbl_valid", {31'd0, operands_valid}, {31'd0, tbl[t].ev});
            check("tbl_byte_ready", {31'd0, byte_ready}, {31'd0, tbl[t].ebr});
            check("tbl_load_count", {28'd0, load_count}, {28'd0, tbl[t].ecnt});
            check("tbl_a_flat", a_flat, tbl[t].ea);
            check("tbl_b_flat", b_flat, tbl[t].eb);
            check("tbl_err", {31'd0, err}, {31'd0, tbl[t].eerr});
        end

        // Second frame right after the handshake.
        send_frame(8'h10);
        check("frame2_a", a_flat, 32'h13121110);
        check("frame2_b", b_flat, 32'h17161514);
        check("frame2_valid", {31'd0, operands_valid}, 32'd1);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("frame2_hs_ready", {31'd0, byte_ready}, 32'd1);

        // Partial frame aborted by clear, then a full frame.
        send(8'h21); send(8'h22); send(8'h23);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("clear_cnt", {28'd0, load_count}, 32'd0);
        send_frame(8'h21);
        check("frame3_a", a_flat, 32'h24232221);
        // clear coinciding with the handshake.
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        check("clear_hs_valid", {31'd0, operands_valid}, 32'd0);

        // ena low blocks byte acceptance.
        send(8'h31); send(8'h32);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        check("ena0_cnt", {28'd0, load_count}, 32'd2);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum, then a good frame with err still sticky, then clear.
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h00);
        check("badchk_err", {31'd0, err}, 32'd1);
        check("badchk_valid", {31'd0, operands_valid}, 32'd0);
        check("badchk_cnt", {28'd0, load_count}, 32'd0);
        send_frame(8'h01);
        check("goodchk_valid", {31'd0, operands_valid}, 32'd1);
        check("goodchk_err", {31'd0, err}, 32'd1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("clear_err", {31'd0, err}, 32'd0);
        check("clear_err_valid", {31'd0, operands_valid}, 32'd0);
`endif

        // Reset mid-frame discards the partial data.
        send(8'h5A); send(8'hA5);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("midrst_a", a_flat, 32'h0);
        check("midrst_cnt", {28'd0, load_count}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 199) != 32'd0);
            e    = ($urandom_range(0, 9) != 32'd0);
            c    = ($urandom_range(0, 39) == 32'd0);
            bv   = ($urandom_range(0, 9) < 32'd7);
            bi   = 8'($urandom);
            if (FRAME == 9 && m_cnt == 8 && !m_full && $urandom_range(0, 3) != 32'd0)
                bi = frame_xor();
            ordy = ($urandom_range(0, 9) < 32'd3);
            apply(r, e, c, bv, bi, ordy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
